// File: rtl/mavg_pkg.sv
// Shared types and constants for the moving-average sequencer.
package mavg_pkg;

  localparam int WIN_W         = 8;
  localparam int DATA_W        = 32;
  localparam int WIN_RST_DEF   = 120;
  localparam int FLUSH_CYC_DEF = 2;
  localparam int DP_LAT_DEF    = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_FILL  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // A zero window is meaningless for the datapath; treat it as one sample.
  function automatic logic [WIN_W-1:0] coerce_win(input logic [WIN_W-1:0] w);
    return (w == '0) ? WIN_W'(1) : w;
  endfunction

endpackage

// File: rtl/mavg_tag_pipe.sv
// 1-bit shift line carrying "emit this result" tags alongside the datapath.
module mavg_tag_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic tag_in,
  output logic tag_out
);

  logic [DEPTH-1:0] line_q;

  // Shift one stage per cycle; clear drops every tag still in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      line_q <= '0;
    end else begin
      line_q <= {line_q[DEPTH-2:0], tag_in};
    end
  end

  assign tag_out = line_q[DEPTH-1];

endmodule

// File: rtl/mavg_ctrl.sv
// Sequencer for the moving-average datapath: streams samples in, flushes the
// datapath on window changes and hides warm-up results until the window fills.
//
// Handshake: a sample is accepted on a rising edge where s_valid && s_ready;
// s_ready depends only on the current state (FILL or RUN), never on s_valid.
// m_valid is a single-cycle pulse with no backpressure.
module mavg_ctrl
  import mavg_pkg::*;
#(
  parameter int DP_LAT    = DP_LAT_DEF,
  parameter int WIN_RST   = WIN_RST_DEF,
  parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [WIN_W-1:0]  cfg_win,
  input  logic              cfg_load,
  input  logic              start,
  input  logic              stop,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [DATA_W-1:0] dp_data_in,
  output logic              dp_e_in,
  output logic [WIN_W-1:0]  dp_mask,
  output logic              dp_nrst,
  input  logic [DATA_W-1:0] dp_data_out,
  output logic              busy,
  output logic              filled,
  output logic [31:0]       sample_cnt,
  output state_t            dbg_state
);

  localparam int              TAG_DEPTH  = DP_LAT + 2;
  localparam logic [7:0]      FLUSH_LAST = 8'(FLUSH_CYC - 1);
  localparam logic [7:0]      DRAIN_LAST = 8'(TAG_DEPTH - 1);
  localparam logic [WIN_W-1:0] WIN_INIT  = WIN_W'(WIN_RST);

  state_t            state_q, state_n;
  logic [7:0]        cyc_q, cyc_n;
  logic [WIN_W-1:0]  win_q, win_n;
  logic              pend_q, pend_n;
  logic [WIN_W-1:0]  fill_q;
  logic [WIN_W:0]    fill_inc;
  logic              fill_done;
  logic              accept;
  logic              tag_in;
  logic              tag_out;

  assign accept    = s_valid && s_ready;
  assign win_n     = cfg_load ? coerce_win(cfg_win) : win_q;
  assign fill_inc  = {1'b0, fill_q} + (WIN_W+1)'(1);
  assign fill_done = fill_inc >= {1'b0, win_q};

  // Next-state logic; stop outranks cfg_load, both outrank the fill edge.
  always_comb begin
    state_n = state_q;
    cyc_n   = cyc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_FLUSH;
          cyc_n   = '0;
        end
      end
      ST_FLUSH: begin
        if (cyc_q == FLUSH_LAST) begin
          state_n = (win_n == WIN_W'(1)) ? ST_RUN : ST_FILL;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc_q + 8'd1;
        end
      end
      ST_FILL: begin
        if (stop || cfg_load) begin
          state_n = ST_DRAIN;
          cyc_n   = '0;
        end else if (accept && fill_done) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop || cfg_load) begin
          state_n = ST_DRAIN;
          cyc_n   = '0;
        end
      end
      ST_DRAIN: begin
        if (cyc_q == DRAIN_LAST) begin
          state_n = (pend_q || cfg_load) ? ST_FLUSH : ST_IDLE;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc_q + 8'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cyc_n   = '0;
      end
    endcase
  end

  // Pending-reconfiguration flag: set by cfg_load while a run is active,
  // cleared by stop and consumed when DRAIN finishes.
  always_comb begin
    pend_n = pend_q;
    case (state_q)
      ST_FILL, ST_RUN: begin
        if (stop)          pend_n = 1'b0;
        else if (cfg_load) pend_n = 1'b1;
      end
      ST_FLUSH: begin
        if (cfg_load) pend_n = 1'b1;
      end
      ST_DRAIN: begin
        if (cyc_q == DRAIN_LAST) pend_n = 1'b0;
        else if (cfg_load)       pend_n = 1'b1;
      end
      default: pend_n = 1'b0;
    endcase
  end

  // State, phase counter, window and pending registers.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      win_q   <= WIN_INIT;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cyc_q   <= cyc_n;
      win_q   <= win_n;
      pend_q  <= pend_n;
    end
  end

  // Fill and sample counters: cleared throughout FLUSH, advanced per accept.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      fill_q     <= '0;
      sample_cnt <= '0;
    end else if (state_q == ST_FLUSH) begin
      fill_q     <= '0;
      sample_cnt <= '0;
    end else if (accept) begin
      sample_cnt <= sample_cnt + 32'd1;
      if (fill_q < win_q) fill_q <= fill_q + WIN_W'(1);
    end
  end

  // Datapath drive: registered sample, one-cycle enable, flush reset.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      dp_data_in <= '0;
      dp_e_in    <= 1'b0;
      dp_nrst    <= 1'b0;
    end else begin
      dp_e_in <= accept;
      dp_nrst <= (state_n != ST_FLUSH);
      if (accept) dp_data_in <= s_data;
    end
  end

  // A result is worth forwarding only once the window holds real samples.
  assign tag_in = accept && ((state_q == ST_RUN) ||
                             (state_q == ST_FILL && state_n == ST_RUN));

  mavg_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .clk     (clk),
    .clr     (!nRST),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Capture the datapath result when its tag leaves the delay line.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      m_valid <= tag_out;
      if (tag_out) m_data <= dp_data_out;
    end
  end

  assign s_ready   = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign filled    = (state_q == ST_RUN);
  assign dp_mask   = win_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mavg_ctrl.sv
// Bench for mavg_ctrl: behavioural moving_avg datapath, scoreboard of expected
// averages with arrival cycles, directed scenarios and randomized runs.
module tb_mavg_ctrl;
  import mavg_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        nRST;
  logic [7:0]  cfg_win;
  logic        cfg_load, start, stop, s_valid;
  logic [31:0] s_data;
  logic        s_ready, m_valid;
  logic [31:0] m_data, dp_data_in;
  logic        dp_e_in;
  logic [7:0]  dp_mask;
  logic        dp_nrst;
  logic [31:0] dp_data_out = '0;
  logic        busy, filled;
  logic [31:0] sample_cnt;
  state_t      dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  mavg_ctrl dut (
    .clk (clk), .nRST (nRST), .cfg_win (cfg_win), .cfg_load (cfg_load),
    .start (start), .stop (stop), .s_valid (s_valid), .s_data (s_data),
    .s_ready (s_ready), .m_valid (m_valid), .m_data (m_data),
    .dp_data_in (dp_data_in), .dp_e_in (dp_e_in), .dp_mask (dp_mask),
    .dp_nrst (dp_nrst), .dp_data_out (dp_data_out), .busy (busy),
    .filled (filled), .sample_cnt (sample_cnt), .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mean of the newest n entries of h (missing entries count as zero).
  function automatic logic [31:0] window_avg(input int unsigned h[$], input int n);
    longint sum = 0;
    for (int i = 0; i < n && i < h.size(); i++) sum += h[h.size()-1-i];
    return 32'(sum / n);
  endfunction

  // ---------------- behavioural moving_avg datapath ----------------
  // Samples e_in on an edge, result valid DP_LAT=1 cycle later.
  logic [31:0] dp_stage = '0;
  int unsigned dp_hist[$];
  always @(posedge clk) begin
    if (dp_nrst !== 1'b1) begin
      dp_hist.delete();
      dp_stage    <= '0;
      dp_data_out <= '0;
    end else begin
      dp_data_out <= dp_stage;
      if (dp_e_in) begin
        dp_hist.push_back(dp_data_in);
        dp_stage <= window_avg(dp_hist, int'(dp_mask));
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  int unsigned mdl_hist[$];
  int          mdl_win = 120;
  logic [31:0] exp_q[$];
  int          exp_t_q[$];

  // Record an accept at posedge number t; emit only once the window is full.
  task automatic model_accept(input logic [31:0] d, input int t);
    mdl_hist.push_back(d);
    if (mdl_hist.size() >= mdl_win) begin
      exp_q.push_back(window_avg(mdl_hist, mdl_win));
      exp_t_q.push_back(t + 3);
    end
  endtask

  logic [31:0] mon_d;
  int          mon_t;
  // Monitor: every m_valid pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (m_valid === 1'b1) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_m_valid", 1, 0);
      end else begin
        mon_d = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        check("m_data", m_data, mon_d);
        check("m_latency_cycle", cyc, mon_t);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_cfg(input logic [7:0] w);
    cfg_win = w; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    mdl_win = (w == 0) ? 1 : int'(w);
    mdl_hist.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mdl_hist.delete();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // Present one sample from a negedge; return at the negedge after acceptance.
  task automatic send(input logic [31:0] d);
    int k = 0;
    s_valid = 1'b1; s_data = d;
    while (!s_ready && k < 50) begin @(negedge clk); k++; end
    if (!s_ready) begin
      check("send_timeout", 1, 0);
      s_valid = 1'b0;
      return;
    end
    model_accept(d, cyc + 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < 80) begin @(negedge clk); k++; end
    check("wait_idle_timeout", (k < 80), 1);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    exp_q.delete(); exp_t_q.delete(); mdl_hist.delete();
    mdl_win = 120;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_dp_data_in"}, dp_data_in, 0);
    check({tag, "_dp_e_in"}, dp_e_in, 0);
    check({tag, "_dp_nrst"}, dp_nrst, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_filled"}, filled, 0);
    check({tag, "_sample_cnt"}, sample_cnt, 0);
    check({tag, "_dp_mask"}, dp_mask, 120);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  int k, nlow, outs0;
  int unsigned seq4[6] = '{10, 20, 30, 40, 50, 60};

  initial begin
    nRST = 1'b0; cfg_win = '0; cfg_load = 1'b0; start = 1'b0; stop = 1'b0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    nRST = 1'b1;
    idle(2);
    check("idle_s_ready", s_ready, 0);

    // Window 4: warm-up suppressed, filled rises on the 4th accept.
    load_cfg(8'd4);
    check("cfg_idle_mask", dp_mask, 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; mdl_hist.delete();
    k = 1; nlow = (dp_nrst == 1'b0) ? 1 : 0;
    while (!s_ready && k < 20) begin
      @(negedge clk); k++;
      if (!dp_nrst) nlow++;
    end
    check("start_to_ready", k, 3);
    check("flush_nrst_low", nlow, 2);
    outs0 = n_out;
    for (int i = 0; i < 6; i++) begin
      send(seq4[i]);
      if (i == 2) check("filled_after_3", filled, 0);
      if (i == 3) check("filled_after_4", filled, 1);
    end
    check("sample_cnt_6", sample_cnt, 6);
    idle(6);
    check("win4_out_count", n_out - outs0, 3);
    do_stop();
    wait_idle();

    // Window 0 coerced to 1: no warm-up suppression.
    load_cfg(8'd0);
    check("win0_mask", dp_mask, 1);
    do_start();
    outs0 = n_out;
    send(32'd7);
    send(32'd9);
    idle(5);
    check("win1_out_count", n_out - outs0, 2);

    // Reconfigure to 2 mid-RUN: 3 DRAIN + 2 FLUSH cycles without s_ready.
    check("pre_reconfig_run", filled, 1);
    load_cfg(8'd2);
    k = 0; nlow = 0;
    while (!s_ready && k < 30) begin
      k++;
      if (!dp_nrst) nlow++;
      @(negedge clk);
    end
    check("reconfig_ready_gap", k, 5);
    check("reconfig_nrst_low", nlow, 2);
    check("reconfig_sample_cnt", sample_cnt, 0);
    check("reconfig_mask", dp_mask, 2);
    outs0 = n_out;
    send(32'd100);
    send(32'd200);
    send(32'd50);
    idle(5);
    check("win2_out_count", n_out - outs0, 2);

    // stop and cfg_load together in RUN: drain to IDLE, window still updates.
    cfg_win = 8'd5; cfg_load = 1'b1; stop = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0; stop = 1'b0; mdl_win = 5;
    nlow = 0;
    for (int i = 0; i < 8; i++) begin
      if (!dp_nrst) nlow++;
      @(negedge clk);
    end
    check("stopcfg_no_flush", nlow, 0);
    check("stopcfg_busy", busy, 0);
    check("stopcfg_state", dbg_state, ST_IDLE);
    check("stopcfg_mask", dp_mask, 5);

    // Reset during RUN with two results in flight.
    load_cfg(8'd2);
    do_start();
    send(32'd1); send(32'd2); send(32'd3);
    idle(6);
    send(32'd11);
    send(32'd13);
    nRST = 1'b0;
    exp_q.delete(); exp_t_q.delete(); mdl_hist.delete();
    mdl_win = 120;
    outs0 = n_out;
    @(negedge clk);
    check_reset_values("midrun_rst");
    nRST = 1'b1;
    idle(8);
    check("midrun_rst_no_output", n_out - outs0, 0);

    // Window 3 with s_valid every other cycle during FILL.
    load_cfg(8'd3);
    do_start();
    for (int i = 0; i < 4; i++) begin
      send(32'(5 * (i + 1)));
      check("toggle_sample_cnt", sample_cnt, i + 1);
      check("toggle_filled", filled, (i >= 2) ? 1 : 0);
      idle(1);
    end
    do_stop();
    wait_idle();

    // Randomized runs against the reference model.
    for (int r = 0; r < 8; r++) begin
      load_cfg(8'($urandom_range(0, 6)));
      do_start();
      for (int j = 0; j < int'($urandom_range(4, 16)); j++) begin
        idle($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0) load_cfg(8'($urandom_range(1, 5)));
        send($urandom_range(0, 5000));
      end
      if ($urandom_range(0, 1) == 1) idle(4);
      do_stop();
      wait_idle();
    end

    // Final report.
    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: bounded run time.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mavg_ctrl.md
# mavg_ctrl

Sequencer for the moving-average datapath (`moving_avg`). It accepts stock samples over a valid/ready stream and drives the datapath's `data_in`, `e_in`, `mask` and `nRST` pins. It flushes the datapath whenever the window size changes and suppresses the warm-up outputs produced before the window is full. It sits between the sample source (file reader or bus) and the result sink.

## Interface
- `DP_LAT`, 1: cycles from the datapath sampling `e_in` to a valid `data_out`.
- `WIN_RST`, 120: window size loaded at reset.
- `FLUSH_CYC`, 2: cycles `dp_nrst` is held low per flush.
- `clk`  in  1  single clock; all logic on the rising edge.
- `nRST`  in  1  reset, synchronous, active-low.
- `cfg_win`  in  8  requested window size; 0 is coerced to 1.
- `cfg_load`  in  1  pulse: latch `cfg_win`.
- `start` / `stop`  in  1  pulses: begin / end a run.
- `s_valid`, `s_data[31:0]` in; `s_ready` out: input sample stream.
- `m_valid`, `m_data[31:0]`  out: averaged result; 1-cycle pulse, no backpressure.
- `dp_data_in`  out  32;  `dp_e_in`  out  1;  `dp_mask`  out  8;  `dp_nrst`  out  1: datapath drive.
- `dp_data_out`  in  32: datapath result.
- `busy`  out  1: state ≠ IDLE.
- `filled`  out  1: state = RUN.
- `sample_cnt`  out  32: samples accepted since the last flush; wraps.

## Operation
- States and transitions:
  - IDLE: `s_ready`=0. `start` → FLUSH.
  - FLUSH: `dp_nrst`=0 for FLUSH_CYC cycles; clears `fill_cnt` and `sample_cnt`. Then → FILL.
  - FILL: `s_ready`=1; results are suppressed. Goes to RUN on the edge that accepts sample number `win` (FILL is skipped if `win`=1).
  - RUN: `s_ready`=1; results are forwarded.
  - DRAIN: `s_ready`=0 for DP_LAT+2 cycles so in-flight results complete. Then → FLUSH if a reconfiguration is pending, else → IDLE.
- Accept = `s_valid && s_ready`. On accept, the controller registers `dp_data_in`=`s_data` and pulses `dp_e_in` for one cycle. `dp_e_in` is 0 on all other cycles.
- Window register `win`:
  - In IDLE, `cfg_load` updates `win` immediately.
  - In FILL/RUN, `cfg_load` updates `win`, sets the pending flag and forces DRAIN.
  - In FLUSH/DRAIN, `cfg_load` updates `win` and sets the pending flag.
  - `dp_mask` = `win` at all times.
- `stop` in FILL/RUN → DRAIN with the pending flag cleared. `stop` and `cfg_load` on the same cycle: `stop` wins, `win` is still updated, the block ends in IDLE.
- `start` is ignored outside IDLE; `stop` is ignored in IDLE, FLUSH and DRAIN.
- Emit tag: each accept pushes a tag into a delay line of DP_LAT+2 stages. The tag is 1 if the accept happened in RUN or on the FILL→RUN edge. When a 1-tag exits, `m_valid`=1 and `m_data`=`dp_data_out` (registered).
- `fill_cnt` is 8-bit and saturates at `win`. `sample_cnt` is 32-bit with modulo wrap.

## Timing
- Reset values: state IDLE, `win`=WIN_RST, `dp_mask`=WIN_RST.
  - 0: `s_ready`, `m_valid`, `m_data`, `dp_data_in`, `dp_e_in`, `dp_nrst`, `busy`, `filled`, `sample_cnt`, pending flag, tag line.
- `dp_nrst` is registered: 0 in reset and FLUSH, 1 otherwise.
- Latency: result for an accept at edge t appears as `m_valid` high in the cycle after edge t+DP_LAT+2 (3 cycles by default).
- Throughput: one sample per cycle in FILL/RUN.
- Minimum `start`→first `s_ready` = FLUSH_CYC+1 cycles.
- Reset mid-run: on the next edge all state returns to reset values. In-flight tags are discarded and no `m_valid` follows.

## Structure
- Package `mavg_pkg` holds:
  - the state enum (IDLE, FLUSH, FILL, RUN, DRAIN);
  - `WIN_W`=8 and `DATA_W`=32;
  - the default constants for WIN_RST and FLUSH_CYC.
- Sub-module `mavg_tag_pipe`: a parameterised 1-bit shift line of depth DP_LAT+2 with synchronous clear, used for the emit tags.
- Everything else (FSM, counters, pending flag, datapath drive registers) lives in `mavg_ctrl`.

## Test plan
- Reset, then `cfg_load` with `cfg_win`=4, `start`, stream 10,20,30,40,50,60 with a behavioural average model (DP_LAT=1) → `m_data`=25,35,45 only. Each arrives 3 cycles after its accept; `filled` rises on the 4th accept.
- `cfg_win`=0 → `dp_mask`=1; stream 7,9 → `m_data`=7,9 with no warm-up suppression.
- `cfg_load` with `cfg_win`=2 mid-RUN → `s_ready` low for 3 cycles (DRAIN) then 2 (FLUSH). `dp_nrst` is low for exactly 2 cycles; `sample_cnt` returns to 0; the first output comes on the 2nd new sample.
- `stop` and `cfg_load` on the same cycle in RUN → DRAIN then IDLE. `win` shows the new value; no flush occurs until the next `start`.
- `nRST` low during RUN with 2 samples in flight → no `m_valid` afterward; all outputs at reset values on the next edge; `dp_mask`=120.
- `s_valid` toggling every other cycle in FILL with `win`=3 → `sample_cnt` counts accepts only; the FILL→RUN transition happens on the 3rd accept.
